cla_result_checker: RTL and testbench

CLA_RESULT_CHECKER -- requirements
Module: cla_result_checker

---
 rtl/cla_chk_pkg.sv | 18 +
 rtl/chk_digit_add.sv | 18 +
 rtl/cla_result_checker.sv | 145 ++++++++++++++
 tb/tb_cla_result_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_chk_pkg.sv
// Shared defaults and state encoding for the carry-lookahead adder result checker.
package cla_chk_pkg;

  localparam int unsigned CHK_WIDTH = 16;
  localparam int unsigned CHK_DIGIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_RESULT
  } chk_state_e;

  // Saturating 16-bit increment for the check/error counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/chk_digit_add.sv
// Combinational DIGIT-bit adder with carry in/out; reused each ADD cycle.
module chk_digit_add
  import cla_chk_pkg::*;
#(
  parameter int unsigned DIGIT = CHK_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] sum,
  output logic             c_out
);

  always_comb begin
    {c_out, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, c_in};
  end

endmodule

// File: rtl/cla_result_checker.sv
// Checks an adder's {c_out,s} against a reference sum built one digit per cycle,
// counting checks/errors and capturing the operands of the first failure.
module cla_result_checker
  import cla_chk_pkg::*;
#(
  parameter int unsigned WIDTH = CHK_WIDTH,
  parameter int unsigned DIGIT = CHK_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [WIDTH-1:0] s,
  input  logic             c_out,
  output logic             res_valid,
  output logic             pass,
  output logic [15:0]      chk_count,
  output logic [15:0]      err_count,
  output logic             fail_seen,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  chk_state_e                  state;
  logic [NDIG-1:0][DIGIT-1:0]  a_r;
  logic [NDIG-1:0][DIGIT-1:0]  b_r;
  logic [NDIG-1:0][DIGIT-1:0]  ref_sum;
  logic [NDIG-1:0][DIGIT-1:0]  ref_full;
  logic [WIDTH-1:0]            s_r;
  logic                        cin_r;
  logic                        cout_r;
  logic                        carry;
  logic [IW-1:0]               idx;
  logic [DIGIT-1:0]            dig_sum;
  logic                        dig_cout;
  logic                        last_digit;

  chk_digit_add #(.DIGIT(DIGIT)) u_digit (
    .a     (a_r[idx]),
    .b     (b_r[idx]),
    .c_in  (carry),
    .sum   (dig_sum),
    .c_out (dig_cout)
  );

  assign last_digit = (idx == IW'(NDIG - 1));

  // The final slice is still combinational on the last ADD edge, so the
  // comparison uses the register contents with that slice merged in.
  always_comb begin
    ref_full      = ref_sum;
    ref_full[idx] = dig_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      pass      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      s_r       <= '0;
      cin_r     <= 1'b0;
      cout_r    <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      ref_sum   <= '0;
    end else begin
      res_valid <= 1'b0;
      pass      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            s_r      <= s;
            cin_r    <= c_in;
            cout_r   <= c_out;
            carry    <= c_in;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ST_ADD;
          end
        end
        ST_ADD: begin
          ref_sum[idx] <= dig_sum;
          carry        <= dig_cout;
          idx          <= idx + IW'(1);
          if (last_digit) begin
            res_valid <= 1'b1;
            pass      <= ({dig_cout, ref_full} == {cout_r, s_r});
            state     <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_count <= '0;
      err_count <= '0;
      fail_seen <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_cin  <= 1'b0;
    end else if (clr) begin
      chk_count <= '0;
      err_count <= '0;
      fail_seen <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_cin  <= 1'b0;
    end else if (state == ST_RESULT) begin
      chk_count <= sat_inc(chk_count);
      if (!pass) begin
        err_count <= sat_inc(err_count);
        if (!fail_seen) begin
          fail_seen <= 1'b1;
          fail_a    <= a_r;
          fail_b    <= b_r;
          fail_cin  <= cin_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_result_checker.sv
// Directed bench for cla_result_checker: cycle model of the check timeline plus
// hand-computed literal expectations for the canonical vectors.
module tb_cla_result_checker;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned ND = W / D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          c_in = 1'b0;
  logic          c_out = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  s = '0;
  logic          in_ready, res_valid, pass, fail_seen, fail_cin;
  logic [15:0]   chk_count, err_count;
  logic [W-1:0]  fail_a, fail_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  cla_result_checker #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .s         (s),
    .c_out     (c_out),
    .res_valid (res_valid),
    .pass      (pass),
    .chk_count (chk_count),
    .err_count (err_count),
    .fail_seen (fail_seen),
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .fail_cin  (fail_cin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_cnt is the number of busy cycles left for the accepted vector
  // (ND ADD cycles + 1 RESULT cycle); counters follow the arithmetic sum.
  int            m_cnt = 0;
  int            m_old;
  bit            m_pass = 1'b0;
  int            m_chk = 0;
  int            m_err = 0;
  bit            m_seen = 1'b0;
  logic [W-1:0]  m_a = '0, m_b = '0, m_pa = '0, m_pb = '0;
  logic          m_cin = 1'b0, m_pcin = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_pass = 0; m_chk = 0; m_err = 0; m_seen = 0;
      m_a = '0; m_b = '0; m_cin = 0;
    end else begin
      m_old = m_cnt;
      if (clr) begin
        m_chk = 0; m_err = 0; m_seen = 0; m_a = '0; m_b = '0; m_cin = 0;
      end else if (m_old == 1) begin
        m_chk = (m_chk == 65535) ? m_chk : m_chk + 1;
        if (!m_pass) begin
          m_err = (m_err == 65535) ? m_err : m_err + 1;
          if (!m_seen) begin
            m_seen = 1; m_a = m_pa; m_b = m_pb; m_cin = m_pcin;
          end
        end
      end
      if (m_old > 0) m_cnt = m_old - 1;
      else if (in_valid) begin
        m_cnt  = ND + 1;
        m_pa   = a; m_pb = b; m_pcin = c_in;
        m_pass = (({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in}) == {c_out, s});
      end
    end
  end

  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("in_ready",  32'(in_ready),  32'(m_cnt == 0));
      chk("res_valid", 32'(res_valid), 32'(m_cnt == 1));
      chk("pass",      32'(pass),      32'((m_cnt == 1) && m_pass));
      chk("chk_count", 32'(chk_count), 32'(m_chk));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("fail_seen", 32'(fail_seen), 32'(m_seen));
      chk("fail_a",    32'(fail_a),    32'(m_a));
      chk("fail_b",    32'(fail_b),    32'(m_b));
      chk("fail_cin",  32'(fail_cin),  32'(m_cin));
    end
  end

  // Offers one vector for a single cycle and returns the negedge count until res_valid.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                      input logic [W-1:0] vs, input logic vcout, output int lat);
    @(negedge clk);
    a = va; b = vb; c_in = vcin; s = vs; c_out = vcout; in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!res_valid && lat < 20);
  endtask

  int lat, pulses, ready_hi;

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    started = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_chk_count", 32'(chk_count), 32'd0);

    send(16'hF0F1, 16'hCA3F, 1'b0, 16'hBB30, 1'b1, lat);
    chk("v1_latency", 32'(lat), 32'd5);
    chk("v1_pass", 32'(pass), 32'd1);
    @(negedge clk);
    chk("v1_chk_count", 32'(chk_count), 32'd1);

    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, lat);
    chk("v2_pass", 32'(pass), 32'd1);
    send(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, lat);
    chk("v3_pass", 32'(pass), 32'd1);

    send(16'hAAAA, 16'h5555, 1'b0, 16'hFFFE, 1'b0, lat);
    chk("v4_pass", 32'(pass), 32'd0);
    @(negedge clk);
    chk("v4_err_count", 32'(err_count), 32'd1);
    chk("v4_fail_seen", 32'(fail_seen), 32'd1);
    chk("v4_fail_a", 32'(fail_a), 32'h0000AAAA);
    chk("v4_fail_b", 32'(fail_b), 32'h00005555);

    send(16'h1234, 16'h1111, 1'b1, 16'h0000, 1'b0, lat);
    chk("v5_pass", 32'(pass), 32'd0);
    @(negedge clk);
    chk("v5_err_count", 32'(err_count), 32'd2);
    chk("v5_fail_a_kept", 32'(fail_a), 32'h0000AAAA);
    chk("v5_fail_cin_kept", 32'(fail_cin), 32'd0);

    // in_valid held high: one acceptance every ND+2 cycles
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; c_in = 1'b0; s = 16'h0002; c_out = 1'b0; in_valid = 1'b1;
    pulses = 0; ready_hi = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (res_valid) pulses++;
      if (in_ready) ready_hi++;
    end
    in_valid = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd5);
    chk("hold_ready_cycles", 32'(ready_hi), 32'd5);
    @(negedge clk);
    chk("hold_chk_count", 32'(chk_count), 32'd10);

    // clr in the RESULT cycle of a failing vector wins over the update
    send(16'h0F0F, 16'h0101, 1'b0, 16'h0000, 1'b1, lat);
    chk("clr_vec_pass", 32'(pass), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_chk_count", 32'(chk_count), 32'd0);
    chk("clr_err_count", 32'(err_count), 32'd0);
    chk("clr_fail_seen", 32'(fail_seen), 32'd0);
    chk("clr_fail_a", 32'(fail_a), 32'd0);

    send(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, lat);
    chk("post_clr_pass", 32'(pass), 32'd1);
    @(negedge clk);
    chk("post_clr_chk_count", 32'(chk_count), 32'd1);

    // reset in the middle of ADD
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; s = 16'h0000; c_out = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_chk_count", 32'(chk_count), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    chk("midrst_no_result", 32'(pulses), 32'd0);
    send(16'hF0F1, 16'hCA3F, 1'b0, 16'hBB30, 1'b1, lat);
    chk("midrst_next_latency", 32'(lat), 32'd5);
    chk("midrst_next_pass", 32'(pass), 32'd1);
    @(negedge clk);
    chk("midrst_next_chk_count", 32'(chk_count), 32'd1);
    chk("midrst_next_err_count", 32'(err_count), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
